// File: rtl/pal_timing_pkg.sv
// Shared PAL timing types and line constants for the composite sync generator.
package pal_timing_pkg;

    typedef enum logic [1:0] {NONE, HSYNC, EQ, BROAD} slot_type_t;

    localparam logic [9:0] LINES_INTERLACED  = 10'd625;
    localparam logic [9:0] LINES_PROGRESSIVE = 10'd312;
    localparam logic [9:0] FIELD2_FIRST_LINE = 10'd313;

    // Field 1 vsync ends at line 3 slot B; field 2 runs 313 slot B up to 316 slot A.
    localparam logic [9:0] VSYNC_F1_END_LINE   = 10'd3;
    localparam logic [9:0] VSYNC_F2_START_LINE = 10'd313;
    localparam logic [9:0] VSYNC_F2_END_LINE   = 10'd316;

endpackage

// File: rtl/pal_slot_lut.sv
// Line number to half-line slot type decode (slot A at h=0, slot B at mid-line).
// PROGRESSIVE_EN restricts the table to the 312-line field-1 layout.
module pal_slot_lut
    import pal_timing_pkg::*;
(
    input  logic [9:0] line_number,
    output slot_type_t slot_a,
    output slot_type_t slot_b
);

    always_comb begin
        slot_a = NONE;
        slot_b = NONE;
        if (line_number <= 10'd2) begin
            slot_a = BROAD;
            slot_b = BROAD;
        end else if (line_number == 10'd3) begin
            slot_a = BROAD;
            slot_b = EQ;
        end else if (line_number <= 10'd5) begin
            slot_a = EQ;
            slot_b = EQ;
        end else if (line_number <= 10'd310) begin
            slot_a = HSYNC;
        end else if (line_number <= 10'd312) begin
            slot_a = EQ;
            slot_b = EQ;
`ifndef PROGRESSIVE_EN
        end else if (line_number == 10'd313) begin
            slot_a = EQ;
            slot_b = BROAD;
        end else if (line_number <= 10'd315) begin
            slot_a = BROAD;
            slot_b = BROAD;
        end else if (line_number <= 10'd317) begin
            slot_a = EQ;
            slot_b = EQ;
        end else if (line_number == 10'd318) begin
            slot_a = EQ;
        end else if (line_number <= 10'd622) begin
            slot_a = HSYNC;
        end else if (line_number == 10'd623) begin
            slot_a = HSYNC;
            slot_b = EQ;
        end else begin
            slot_a = EQ;
            slot_b = EQ;
`endif
        end
    end

endmodule

// File: rtl/pal_csync_generator.sv
// PAL composite sync generator: line/pixel timebase, slot pulse shaping, registered sync outputs.
// Define PROGRESSIVE_EN for a non-interlaced 312-line frame with field held at 0.
module pal_csync_generator
    import pal_timing_pkg::*;
#(
    parameter int LINE_CYCLES = 6400,
    parameter int HSYNC_WIDTH = 470,
    parameter int EQ_WIDTH    = 235,
    parameter int BROAD_WIDTH = 2730
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        csync_n,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        field,
    output logic [9:0]  line_number,
    output logic [12:0] h_count,
    output logic        line_start
);

    localparam logic [12:0] H_LAST  = 13'(LINE_CYCLES - 1);
    localparam logic [12:0] H_HALF  = 13'(LINE_CYCLES / 2);
    localparam logic [12:0] W_HSYNC = 13'(HSYNC_WIDTH);
    localparam logic [12:0] W_EQ    = 13'(EQ_WIDTH);
    localparam logic [12:0] W_BROAD = 13'(BROAD_WIDTH);
`ifdef PROGRESSIVE_EN
    localparam logic [9:0]  LINE_LAST = LINES_PROGRESSIVE;
`else
    localparam logic [9:0]  LINE_LAST = LINES_INTERLACED;
`endif

    function automatic logic pulse_low(input slot_type_t t, input logic [12:0] s);
        case (t)
            HSYNC:   return s < W_HSYNC;
            EQ:      return s < W_EQ;
            BROAD:   return s < W_BROAD;
            default: return 1'b0;
        endcase
    endfunction

    logic [12:0] h_cnt_p0;
    logic [9:0]  line_p0;
    slot_type_t  slot_a, slot_b;
    logic        in_b, csync_low, vsync_low, field_nxt;
    logic [12:0] slot_ofs;

    // Stage 0: free-running timebase, parked at frame start while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_p0 <= '0;
            line_p0  <= 10'd1;
        end else if (!en) begin
            h_cnt_p0 <= '0;
            line_p0  <= 10'd1;
        end else if (h_cnt_p0 == H_LAST) begin
            h_cnt_p0 <= '0;
            line_p0  <= (line_p0 == LINE_LAST) ? 10'd1 : line_p0 + 10'd1;
        end else begin
            h_cnt_p0 <= h_cnt_p0 + 13'd1;
        end
    end

    pal_slot_lut u_slot_lut (
        .line_number (line_p0),
        .slot_a      (slot_a),
        .slot_b      (slot_b)
    );

    always_comb begin
        in_b      = (h_cnt_p0 >= H_HALF);
        slot_ofs  = in_b ? (h_cnt_p0 - H_HALF) : h_cnt_p0;
        csync_low = pulse_low(in_b ? slot_b : slot_a, slot_ofs);
        vsync_low = (line_p0 < VSYNC_F1_END_LINE) || (line_p0 == VSYNC_F1_END_LINE && !in_b);
`ifdef PROGRESSIVE_EN
        field_nxt = 1'b0;
`else
        vsync_low = vsync_low || (line_p0 == VSYNC_F2_START_LINE && in_b)
                  || (line_p0 > VSYNC_F2_START_LINE && line_p0 < VSYNC_F2_END_LINE);
        field_nxt = (line_p0 >= FIELD2_FIRST_LINE);
`endif
    end

    logic        csync_n_p1, hsync_n_p1, vsync_n_p1, field_p1, line_start_p1;
    logic [9:0]  line_p1;
    logic [12:0] h_cnt_p1;

    // Stage 1: registered outputs; disable drops straight to the idle state
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !en) begin
            csync_n_p1    <= 1'b1;
            hsync_n_p1    <= 1'b1;
            vsync_n_p1    <= 1'b1;
            field_p1      <= 1'b0;
            line_p1       <= 10'd1;
            h_cnt_p1      <= '0;
            line_start_p1 <= 1'b0;
        end else begin
            csync_n_p1    <= ~csync_low;
            hsync_n_p1    <= ~(h_cnt_p0 < W_HSYNC);
            vsync_n_p1    <= ~vsync_low;
            field_p1      <= field_nxt;
            line_p1       <= line_p0;
            h_cnt_p1      <= h_cnt_p0;
            line_start_p1 <= (h_cnt_p0 == '0);
        end
    end

    assign csync_n     = csync_n_p1;
    assign hsync_n     = hsync_n_p1;
    assign vsync_n     = vsync_n_p1;
    assign field       = field_p1;
    assign line_number = line_p1;
    assign h_count     = h_cnt_p1;
    assign line_start  = line_start_p1;

endmodule

// File: tb/tb_pal_csync_generator.sv
// Directed bench for pal_csync_generator using a shortened 64-clock line.
module tb_pal_csync_generator;

    localparam int LC   = 64;
    localparam int HW   = 5;
    localparam int EQW  = 2;
    localparam int BW   = 27;
    localparam int HALF = LC / 2;
`ifdef PROGRESSIVE_EN
    localparam int FRAME_LINES = 312;
    localparam int VS_LOWS     = 160;
    localparam int VS_FALLS    = 1;
    localparam int FIELD_HIGHS = 0;
`else
    localparam int FRAME_LINES = 625;
    localparam int VS_LOWS     = 320;
    localparam int VS_FALLS    = 2;
    localparam int FIELD_HIGHS = 313 * LC;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        csync_n, hsync_n, vsync_n, field, line_start;
    logic [9:0]  line_number;
    logic [12:0] h_count;

    int tests = 0;
    int fails = 0;

    pal_csync_generator #(
        .LINE_CYCLES (LC),
        .HSYNC_WIDTH (HW),
        .EQ_WIDTH    (EQW),
        .BROAD_WIDTH (BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .csync_n     (csync_n),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .field       (field),
        .line_number (line_number),
        .h_count     (h_count),
        .line_start  (line_start)
    );

    always #5 clk = ~clk;

    // Leaves the bench on the negedge sample of line 1, h_count 0.
    task automatic restart();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_to(input int line, input int h);
        int n = 0;
        while (!(line_number == 10'(line) && h_count == 13'(h)) && n < 50000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 50000) begin
            fails++;
            $display("FAIL run_to: line %0d h %0d not reached, at line %0d h %0d", line, h, line_number, h_count);
        end
    endtask

    // Samples one full line starting at the current sample.
    task automatic measure_line(output int lows, output int falls, output int f0, output int f1,
                                output int hs_lows, output int ls_cnt);
        logic prev = 1'b1;
        lows = 0; falls = 0; f0 = -1; f1 = -1; hs_lows = 0; ls_cnt = 0;
        for (int i = 0; i < LC; i++) begin
            if (!csync_n) lows++;
            if (prev && !csync_n) begin
                if (falls == 0) f0 = int'(h_count);
                else if (falls == 1) f1 = int'(h_count);
                falls++;
            end
            if (!hsync_n) hs_lows++;
            if (line_start) ls_cnt++;
            prev = csync_n;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({csync_n, hsync_n, vsync_n, field, line_start} !== 5'b11100 ||
            line_number !== 10'd1 || h_count !== 13'd0) begin
            fails++;
            $display("FAIL reset: got cs%b hs%b vs%b f%b ls%b line %0d h %0d, want cs1 hs1 vs1 f0 ls0 line 1 h 0",
                     csync_n, hsync_n, vsync_n, field, line_start, line_number, h_count);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (csync_n !== 1'b1 || h_count !== 13'd0) begin
            fails++;
            $display("FAIL idle_en_low: got cs%b h %0d, want cs1 h 0", csync_n, h_count);
        end
    endtask

    task automatic test_first_line();
        int lows, falls, f0, f1, hsl, lsc;
        restart();
        tests++;
        if (csync_n !== 1'b0 || hsync_n !== 1'b0 || vsync_n !== 1'b0 || line_start !== 1'b1 ||
            h_count !== 13'd0 || line_number !== 10'd1) begin
            fails++;
            $display("FAIL first_cycle: got cs%b hs%b vs%b ls%b h %0d line %0d, want cs0 hs0 vs0 ls1 h 0 line 1",
                     csync_n, hsync_n, vsync_n, line_start, h_count, line_number);
        end
        measure_line(lows, falls, f0, f1, hsl, lsc);
        tests++;
        if (lows != 2 * BW || falls != 2 || f0 != 0 || f1 != HALF) begin
            fails++;
            $display("FAIL line1_broad: lows %0d falls %0d at %0d/%0d, want %0d lows 2 falls at 0/%0d",
                     lows, falls, f0, f1, 2 * BW, HALF);
        end
        tests++;
        if (hsl != HW || lsc != 1) begin
            fails++;
            $display("FAIL line1_hsync: hsync lows %0d line_start %0d, want %0d and 1", hsl, lsc, HW);
        end
    endtask

    task automatic test_line_pulses();
        int lows, falls, f0, f1, hsl, lsc;
        run_to(4, 0);
        measure_line(lows, falls, f0, f1, hsl, lsc);
        tests++;
        if (lows != 2 * EQW || falls != 2 || f0 != 0 || f1 != HALF) begin
            fails++;
            $display("FAIL line4_eq: lows %0d falls %0d at %0d/%0d, want %0d lows 2 falls at 0/%0d",
                     lows, falls, f0, f1, 2 * EQW, HALF);
        end
        run_to(6, 0);
        measure_line(lows, falls, f0, f1, hsl, lsc);
        tests++;
        if (lows != HW || falls != 1 || f0 != 0 || hsl != HW) begin
            fails++;
            $display("FAIL line6_hsync: lows %0d falls %0d first %0d hs %0d, want %0d 1 0 %0d",
                     lows, falls, f0, hsl, HW, HW);
        end
    endtask

    task automatic test_frame();
        int ls_cnt = 0, vs_lows = 0, vs_falls = 0, f_highs = 0, bad_iv = 0, bad_field = 0;
        int max_line = 0, last_fall = -1;
        logic cs_prev = 1'b1, vs_prev = 1'b1, f_prev = 1'b0;
        restart();
        for (int i = 0; i < FRAME_LINES * LC; i++) begin
            if (line_start) ls_cnt++;
            if (!vsync_n) vs_lows++;
            if (vs_prev && !vsync_n) vs_falls++;
            if (field) f_highs++;
            if (!f_prev && field && !(line_number == 10'd313 && h_count == 13'd0)) bad_field++;
            if (cs_prev && !csync_n) begin
                if (last_fall >= 0 && (i - last_fall) != HALF && (i - last_fall) != LC) bad_iv++;
                last_fall = i;
            end
            if (int'(line_number) > max_line) max_line = int'(line_number);
            cs_prev = csync_n; vs_prev = vsync_n; f_prev = field;
            @(negedge clk);
        end
        tests++;
        if (ls_cnt != FRAME_LINES || max_line != FRAME_LINES) begin
            fails++;
            $display("FAIL frame_lines: strobes %0d max line %0d, want %0d", ls_cnt, max_line, FRAME_LINES);
        end
        tests++;
        if (vs_lows != VS_LOWS || vs_falls != VS_FALLS) begin
            fails++;
            $display("FAIL frame_vsync: lows %0d pulses %0d, want %0d and %0d", vs_lows, vs_falls, VS_LOWS, VS_FALLS);
        end
        tests++;
        if (f_highs != FIELD_HIGHS || bad_field != 0) begin
            fails++;
            $display("FAIL frame_field: high %0d bad rises %0d, want %0d and 0", f_highs, bad_field, FIELD_HIGHS);
        end
        tests++;
        if (bad_iv != 0) begin
            fails++;
            $display("FAIL frame_csync_intervals: %0d intervals not %0d/%0d", bad_iv, HALF, LC);
        end
        tests++;
        if (line_number !== 10'd1 || h_count !== 13'd0 || line_start !== 1'b1 || field !== 1'b0) begin
            fails++;
            $display("FAIL frame_wrap: line %0d h %0d ls %b f %b, want line 1 h 0 ls 1 f 0",
                     line_number, h_count, line_start, field);
        end
    endtask

    task automatic test_en_gap();
        int bad = 0;
        restart();
        run_to(200, 10);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ({csync_n, hsync_n, vsync_n, field, line_start} !== 5'b11100 ||
                line_number !== 10'd1 || h_count !== 13'd0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL en_gap_idle: %0d of 50 gap samples not idle, want 0", bad);
        end
        en = 1'b1;
        @(negedge clk);
        tests++;
        if (csync_n !== 1'b0 || line_number !== 10'd1 || h_count !== 13'd0 || line_start !== 1'b1) begin
            fails++;
            $display("FAIL en_gap_restart: cs%b line %0d h %0d ls%b, want cs0 line 1 h 0 ls1",
                     csync_n, line_number, h_count, line_start);
        end
    endtask

    task automatic test_async_reset();
        restart();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (csync_n !== 1'b1 || vsync_n !== 1'b1 || h_count !== 13'd0) begin
            fails++;
            $display("FAIL async_reset: cs%b vs%b h %0d, want cs1 vs1 h 0", csync_n, vsync_n, h_count);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_line_pulses();
        test_frame();
        test_en_gap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
